// File: rtl/regfile_pkg.sv
// Shared types and default constants for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_ZERO_REG = 31;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp.sv
// Two-read / one-write register file with hardwired-zero entry and clear sweep.
// Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB,
    output logic              busy
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              busy_q;
    logic              wr_ok;

    assign wr_ok = write && (state_q == IDLE) && (wrAddr != ZADDR);
    assign busy  = busy_q;

    // busy_q mirrors the next state so it is high exactly while in CLEAR
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_ok) begin
                mem_q[wrAddr] <= wrData;
            end
        end
    end

    always_comb begin
        rdDataA = '0;
        rdDataB = '0;
        if (!busy_q) begin
            if (rdAddrA != ZADDR) begin
                rdDataA = mem_q[rdAddrA];
            end
            if (rdAddrB != ZADDR) begin
                rdDataB = mem_q[rdAddrB];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wrAddr == rdAddrA)) begin
                rdDataA = wrData;
            end
            if (wr_ok && (wrAddr == rdAddrB)) begin
                rdDataB = wrData;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed cases plus random traffic vs a model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst, clr, write;
    logic [4:0]  wrAddr, rdAddrA, rdAddrB;
    logic [63:0] wrData, rdDataA, rdDataB;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q [32];
    int          sweep = 0;
    int          n;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst(rst), .clr(clr), .write(write),
        .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
        .rdDataA(rdDataA), .rdDataB(rdDataB), .busy(busy)
    );

    function automatic logic [63:0] ref_rd(input logic [4:0] a);
        if (sweep > 0 || a == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (write && a == wrAddr) return wrData;
`endif
        return exp_q[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, o, e);
        end
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_A"}, rdDataA, ref_rd(rdAddrA));
        chk({tag, "_B"}, rdDataB, ref_rd(rdAddrB));
        chk({tag, "_busy"}, {63'd0, busy}, {63'd0, sweep > 0});
    endtask

    // A sweep writes zero to every entry and blocks writes, so on completion
    // the whole file is zero regardless of prior contents.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            sweep = 32;
        end else if (sweep > 0) begin
            sweep--;
            if (sweep == 0) foreach (exp_q[i]) exp_q[i] = 64'd0;
        end else if (clr) begin
            sweep = 32;
        end else if (write && wrAddr != 5'd31) begin
            exp_q[wrAddr] = wrData;
        end
        #1;
    endtask

    task automatic idle_in();
        rst = 0; clr = 0; write = 0;
    endtask

    task automatic count_busy(input string tag);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            chk({tag, "_rd0"}, rdDataA | rdDataB, 64'd0);
            tick();
            n++;
        end
        chk({tag, "_len"}, 64'(n), 64'd32);
    endtask

    initial begin
        foreach (exp_q[i]) exp_q[i] = 64'd0;
        rst = 1; clr = 0; write = 0;
        wrAddr = 0; wrData = 0; rdAddrA = 0; rdAddrB = 0;
        tick();
        idle_in();
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd1);
        count_busy("rst_sweep");
        chk("rst_done", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            rdAddrA = 5'(i); rdAddrB = 5'(31 - i);
            #1;
            chk("zero_A", rdDataA, 64'd0);
            chk("zero_B", rdDataB, 64'd0);
        end

        write = 1; wrAddr = 5; wrData = 64'hDEADBEEF_CAFEF00D;
        tick();
        write = 0; rdAddrA = 5; rdAddrB = 5;
        #1;
        chk("wr5_A", rdDataA, 64'hDEADBEEF_CAFEF00D);
        chk("wr5_B", rdDataB, 64'hDEADBEEF_CAFEF00D);

        write = 1; wrAddr = 30; wrData = 64'h3030;
        tick();
        wrAddr = 31; wrData = 64'h1234;
        tick();
        write = 0; rdAddrA = 31; rdAddrB = 30;
        #1;
        chk("xzr_rd", rdDataA, 64'd0);
        chk("r30_kept", rdDataB, 64'h3030);

        write = 1; wrAddr = 7; wrData = 64'h77;
        tick();
        wrData = 64'hAA; rdAddrA = 7; rdAddrB = 7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cyc_A", rdDataA, 64'hAA);
        chk("same_cyc_B", rdDataB, 64'hAA);
`else
        chk("same_cyc_A", rdDataA, 64'h77);
        chk("same_cyc_B", rdDataB, 64'h77);
`endif
        tick();
        write = 0;
        #1;
        chk("after_wr7", rdDataA, 64'hAA);

        write = 1; wrAddr = 3; wrData = 64'h33;
        tick();
        write = 0; clr = 1;
        tick();
        clr = 0;
        chk("clr_busy", {63'd0, busy}, 64'd1);
        write = 1; wrAddr = 3; wrData = 64'h55;
        for (int i = 0; i < 9; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        count_busy("restart");
        write = 0; rdAddrA = 3; rdAddrB = 7;
        #1;
        chk("r3_dropped", rdDataA, 64'd0);
        chk("r7_cleared", rdDataB, 64'd0);

        for (int i = 0; i < 400; i++) begin
            rdAddrA = 5'($urandom); rdAddrB = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rdAddrB = rdAddrA;
            write  = 1'($urandom_range(0, 1));
            wrAddr = ($urandom_range(0, 3) == 0) ? rdAddrA : 5'($urandom);
            wrData = {$urandom, $urandom};
            clr = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 149) == 0);
            #1;
            check_reads("rand");
            tick();
        end

        idle_in();
        n = 0;
        while (sweep > 0 && n < 40) begin
            tick();
            n++;
        end
        #1;
        check_reads("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 31, index of the hardwired-zero entry (LEGv8 XZR).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port clr  input  1  request a full clear sweep.
REQ-007 SHALL have port write  input  1  write enable.
REQ-008 SHALL have port wrAddr  input  ADDR_W  write address.
REQ-009 SHALL have port wrData  input  DATA_W  write data.
REQ-010 SHALL have ports rdAddrA / rdAddrB  input  ADDR_W  read addresses A / B.
REQ-011 SHALL have ports rdDataA / rdDataB  output  DATA_W  read data A / B.
REQ-012 SHALL have port busy  output  1  high while a clear sweep is in progress.

Function
REQ-013 SHALL implement FSM states IDLE and CLEAR, plus a clear counter of ADDR_W bits.
REQ-014 SHALL move IDLE->CLEAR with counter=0 on the edge where clr=1; clr is ignored in CLEAR.
REQ-015 SHALL, in CLEAR, write 0 to the entry indexed by the counter each cycle and increment the counter.
REQ-016 SHALL move CLEAR->IDLE on the edge where counter==DEPTH-1; a sweep therefore lasts exactly DEPTH cycles.
REQ-017 SHALL drive busy=1 exactly while the state is CLEAR.
REQ-018 SHALL, in IDLE with write=1 and wrAddr!=ZERO_REG, store wrData into entry wrAddr on the rising edge.
REQ-019 SHALL ignore write while busy=1, and SHALL ignore every write to ZERO_REG.
REQ-020 SHALL read combinationally: rdDataX = entry[rdAddrX], with zero latency.
REQ-021 SHALL return 0 for reads of ZERO_REG, and SHALL return 0 on both ports while busy=1.
REQ-022 SHALL allow both read ports to read the same address at once with identical results.
REQ-023 SHALL, on a read of an address written in the same cycle, return the pre-edge value unless REGFILE_BYPASS_EN is defined.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, enter CLEAR with counter=0, whatever the current state; a reset mid-sweep restarts the sweep from entry 0.
REQ-025 SHALL have rst take priority over clr and write in the same cycle.
REQ-026 SHALL have outputs after reset of busy=1 and rdDataA=rdDataB=0 until the sweep completes; all entries read 0 afterwards.

Configuration
REQ-027 SHALL, when REGFILE_BYPASS_EN is defined, forward wrData to rdDataX in the same cycle if write=1, busy=0, wrAddr==rdAddrX and wrAddr!=ZERO_REG.
REQ-028 SHALL, when REGFILE_BYPASS_EN is undefined, add no forwarding logic; the write becomes visible the cycle after the edge.

Structure
REQ-029 SHALL place the FSM state typedef (IDLE, CLEAR) and the default constants DATA_W=64, ADDR_W=5, ZERO_REG=31 in shared package regfile_pkg.
REQ-030 SHALL be a single module with no sub-modules; storage is one DEPTH x DATA_W array.

Verification
REQ-031 Bench SHALL check: rst for 1 cycle -> busy=1 for exactly 32 cycles, then 0; all 32 entries read 0 afterwards.
REQ-032 Bench SHALL check: write 0xDEADBEEF_CAFEF00D to entry 5, then read A=5 and B=5 next cycle -> both return 0xDEADBEEF_CAFEF00D.
REQ-033 Bench SHALL check: write 0x1234 to entry 31 -> read 31 returns 0; entry 30 is unaffected.
REQ-034 Bench SHALL check: write 0xAA to entry 7 while reading 7 in the same cycle -> 0xAA with REGFILE_BYPASS_EN defined, the old value without it.
REQ-035 Bench SHALL check: clr=1, then rst=1 at sweep cycle 10 -> the sweep restarts and busy stays high 32 more cycles; a write of 0x55 to entry 3 during the sweep is dropped and entry 3 reads 0.
